// File: rtl/karatsuba_seq_ctrl.sv
// Iterative Karatsuba multiplier controller: one N x N unsigned product via three
// partial products run in sequence through a single external fixed-latency sub-multiplier.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for operands, in_ready high
// S_MUL_X   | a*c in flight on the sub-multiplier
// S_MUL_Y   | b*d in flight on the sub-multiplier
// S_MUL_Z   | (a+b)*(c+d) in flight on the sub-multiplier
// S_COMBINE | merge px/py/pz into the full product
// S_DONE    | product presented, held until out_ready
module karatsuba_seq_ctrl #(
   parameter int N       = 8,
   parameter int MUL_LAT = 0,
   localparam int H      = N / 2 + N % 2,
   localparam int L      = N - H,
   localparam int W      = H + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     u,
   input  logic [N-1:0]     v,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   r,
   output logic             busy,
   output logic             mul_en,
   output logic [W-1:0]     mul_a,
   output logic [W-1:0]     mul_b,
   input  logic [2*W-1:0]   mul_r
);

   localparam int LCW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
   localparam logic [LCW-1:0] LAT_TC = LCW'(MUL_LAT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_X,
      S_MUL_Y,
      S_MUL_Z,
      S_COMBINE,
      S_DONE
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [LCW-1:0]   lat_cnt;
   logic [L-1:0]     a_q;
   logic [H-1:0]     b_q;
   logic [L-1:0]     c_q;
   logic [H-1:0]     d_q;
   logic [2*L-1:0]   px;
   logic [2*H-1:0]   py;
   logic [2*H+1:0]   pz;
   logic [2*N-1:0]   r_reg;

   logic             accept;
   logic             lat_tc;
   logic [2*N-1:0]   px_e;
   logic [2*N-1:0]   py_e;
   logic [2*N-1:0]   pz_e;
   logic [2*N-1:0]   cross_sum;
   logic [2*N-1:0]   comb_sum;

   assign accept    = in_valid & in_ready;
   assign lat_tc    = (lat_cnt == LAT_TC);
   assign busy      = (state != S_IDLE);
   assign out_valid = (state == S_DONE);
   assign r         = r_reg;

   // All partial products fit in 2N bits for N >= 2, so the merge wraps modulo 2^2N.
   assign px_e      = (2*N)'(px);
   assign py_e      = (2*N)'(py);
   assign pz_e      = (2*N)'(pz);
   assign cross_sum = pz_e - px_e - py_e;
   assign comb_sum  = (px_e << (2 * H)) + (cross_sum << H) + py_e;

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      mul_en     = 1'b0;
      mul_a      = '0;
      mul_b      = '0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) next_state = S_MUL_X;
         end
         S_MUL_X: begin
            mul_en = 1'b1;
            mul_a  = W'(a_q);
            mul_b  = W'(c_q);
            if (lat_tc) next_state = S_MUL_Y;
         end
         S_MUL_Y: begin
            mul_en = 1'b1;
            mul_a  = W'(b_q);
            mul_b  = W'(d_q);
            if (lat_tc) next_state = S_MUL_Z;
         end
         S_MUL_Z: begin
            mul_en = 1'b1;
            mul_a  = W'(a_q) + W'(b_q);
            mul_b  = W'(c_q) + W'(d_q);
            if (lat_tc) next_state = S_COMBINE;
         end
         S_COMBINE: begin
            next_state = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               in_ready   = 1'b1;
               next_state = in_valid ? S_MUL_X : S_IDLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         lat_cnt <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         px      <= '0;
         py      <= '0;
         pz      <= '0;
         r_reg   <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            a_q     <= u[N-1:H];
            b_q     <= u[H-1:0];
            c_q     <= v[N-1:H];
            d_q     <= v[H-1:0];
            lat_cnt <= '0;
         end else if (mul_en) begin
            // mul_r is only trusted on the last cycle of each multiply state
            if (lat_tc) begin
               lat_cnt <= '0;
               case (state)
                  S_MUL_X: px <= mul_r[2*L-1:0];
                  S_MUL_Y: py <= mul_r[2*H-1:0];
                  S_MUL_Z: pz <= mul_r;
                  default: ;
               endcase
            end else begin
               lat_cnt <= lat_cnt + LCW'(1);
            end
         end
         if (state == S_COMBINE) r_reg <= comb_sum;
      end
   end

endmodule
